register_file_wb: RTL
=====================

Name: register_file_wb

Overview:
- Write-side counterpart of the register-file read multiplexing: a 16-entry architectural register file for the pipelined processor.
- The writeback stage drives one write port. A 4-to-16 one-hot decoder, the inverse of the 16:1 select, steers the write.
- Three combinational read ports serve the decode stage, with same-cycle write-to-read bypass.
- R15 is not stored. It reads as the externally supplied PC+8 value.

Parameters:
- W, 32, data width of every register and data port.
- RESET_VAL, 0, value loaded into R0..R14 on reset.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset.
- we, input, 1, write enable from the writeback stage.
- wa, input, 4, write address.
- wd, input, W, write data.
- ra1, input, 4, read address port 1 (Rn).
- ra2, input, 4, read address port 2 (Rm).
- ra3, input, 4, read address port 3 (Rd, store data).
- r15_in, input, W, PC+8 value returned for reads of address 15.
- rd1, output, W, read data port 1.
- rd2, output, W, read data port 2.
- rd3, output, W, read data port 3.
- wr_err, output, 1, sticky flag: a write to R15 was attempted.

Behaviour:
- Storage: 15 registers, R0..R14, each W bits. Address 15 has no storage.
- Reset: evaluated on the clk rising edge while reset=0.
  - R0..R14 <= RESET_VAL; wr_err <= 0.
  - Reset has priority over any write in the same cycle; that write is dropped.
  - During reset, rd1..rd3 reflect RESET_VAL, or r15_in for address 15.
- Write decode: a one-hot 16-bit enable vector, en[i] = we & (wa == i).
  - Exactly one bit is set when we=1; all bits are 0 when we=0.
- Write: on the rising edge with reset=1 and we=1 and wa in 0..14, R[wa] <= wd. One-cycle latency to storage.
- Write to wa=15: storage is unchanged and wr_err <= 1.
  - wr_err stays 1 until the next reset.
  - The write is not forwarded; reads of address 15 still return r15_in.
- Read: each port is fully combinational (zero latency).
  - rdN = r15_in when raN=15.
  - Otherwise rdN = wd when we=1 and wa=raN and reset=1 (bypass: the writeback value is visible in the same cycle).
  - Otherwise rdN = R[raN].
- Bypass is gated by reset. While reset=0 the bypass path is disabled, so reads never show data that reset will discard.
- All three read ports may address the same register simultaneously, and each returns an identical value.
- Writes and reads in the same cycle to different addresses are independent.
- No X propagation: out-of-range cases cannot occur (4-bit address), and every output has a defined value every cycle.

Decomposition:
- Shared package constants:
  - REG_PC = 4'd15
  - NUM_STORED_REGS = 15
  - ADDR_W = 4
- One natural sub-module, decoder4to16 (4-bit address plus enable in, 16-bit one-hot out). It is the structural inverse of the 16:1 select and is reused for write-enable generation.
- Read ports reuse the existing 16:1 multiplexer, with input 15 tied to r15_in. The bypass override is applied after the multiplexer.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with we=1, wa=3, wd=0xDEAD → rd1 (ra1=3) = 0x0 after reset and during it, with no bypass of 0xDEAD; wr_err=0.
2. Basic write/read: we=1, wa=5, wd=0x12345678 for one edge, then we=0 → next cycle rd2 (ra2=5) = 0x12345678; all other registers remain 0.
3. Same-cycle bypass: R7 holds 0x11; drive we=1, wa=7, wd=0xA5A5A5A5 with ra1=ra2=ra3=7 → all three rd outputs = 0xA5A5A5A5 before the edge and after it.
4. R15 handling: r15_in=0x00000108; write wa=15, wd=0xFFFFFFFF → rd1 (ra1=15) = 0x108 throughout; wr_err=1 from the next cycle and stays 1 until a reset pulse clears it to 0.
5. Decoder sweep: write wd=0x100+i to each wa=i for i=0..14 → reading back each register returns 0x100+i, with no aliasing.
6. Reset mid-operation: alternate writes to R2 with reset=0 asserted on the same edge as we=1, wa=2, wd=0x77 → R2 = 0 after the edge; the following write of 0x88 with reset=1 → R2 = 0x88.

Source files
------------

// File: rtl/register_file_wb_pkg.sv
// Shared constants for the writeback-side register file.
// Imported by the decoder and the register file top.
package register_file_wb_pkg;

   localparam int ADDR_W = 4;
   localparam int NUM_STORED_REGS = 15;
   localparam logic [ADDR_W-1:0] REG_PC = 4'd15;

endpackage

// File: rtl/register_file_wb_decoder4to16.sv
// 4-to-16 one-hot decoder, the inverse of the 16:1 read select.
// Drives the per-register write enables.
module decoder4to16
   import register_file_wb_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   input  logic              en,
   output logic [15:0]       onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/register_file_wb.sv
// 16-entry register file: one write port, three combinational read ports
// with same-cycle bypass; R15 reads return the supplied PC+8 value.
module register_file_wb
   import register_file_wb_pkg::*;
#(
   parameter int          W         = 32,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [W-1:0]      wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic [ADDR_W-1:0] ra3,
   input  logic [W-1:0]      r15_in,
   output logic [W-1:0]      rd1,
   output logic [W-1:0]      rd2,
   output logic [W-1:0]      rd3,
   output logic              wr_err
);

   logic [W-1:0] regs [NUM_STORED_REGS];
   logic [W-1:0] view [16];
   logic [15:0]  en;

   decoder4to16 u_dec (
      .addr   (wa),
      .en     (we),
      .onehot (en)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_STORED_REGS; i++) regs[i] <= RESET_VAL;
         wr_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_STORED_REGS; i++)
            if (en[i]) regs[i] <= wd;
         if (en[REG_PC]) wr_err <= 1'b1;
      end
   end

   // 16:1 select source; slot 15 is the PC+8 input, not storage
   always_comb begin
      for (int i = 0; i < NUM_STORED_REGS; i++) view[i] = regs[i];
      view[REG_PC] = r15_in;
   end

   function automatic logic [W-1:0] rd_sel(input logic [ADDR_W-1:0] ra);
      logic [W-1:0] v;
      v = view[ra];
      if (ra != REG_PC && we && reset && wa == ra) v = wd;
      return v;
   endfunction

   assign rd1 = rd_sel(ra1);
   assign rd2 = rd_sel(ra2);
   assign rd3 = rd_sel(ra3);

endmodule
